// File: rtl/mem_pkg.sv
// Shared types and defaults for the banked memory.
// Holds the sweep FSM state type and parameter defaults.
package mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 5;
  localparam int DEF_N_BANK = 2;

  // Word count of one bank for a given address width.
  function automatic int bank_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One storage bank: a single write port and one registered read port.
// The read is read-first: a same-edge write is not visible until later.
module mem_bank
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = bank_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; holds its value when no read is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_memory.sv
// N_BANK parallel banks sharing one address, with a clear sweep FSM.
// Define MEM_BYPASS_EN to forward same-address write data to reads.
module banked_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_BANK = DEF_N_BANK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [N_BANK*DATA_W-1:0] wr_data,
  input  logic [N_BANK-1:0]        wr_mask,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     o_en,
  output logic [N_BANK*DATA_W-1:0] rd_data,
  output logic                     rd_valid
);

  localparam int W = N_BANK * DATA_W;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_rd_valid;

  logic              w_clr;
  logic              w_last;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W-1:0] w_waddr;
  logic [N_BANK-1:0] w_bank_we;
  logic [W-1:0]      w_wdata;
  logic [W-1:0]      w_bank_q;
  logic [W-1:0]      w_rd_word;

  assign w_clr    = (r_state == CLEAR);
  assign w_last   = (r_clr_addr == {ADDR_W{1'b1}});
  assign w_wr_acc = !w_clr && wr_en && !init;
  assign w_rd_acc = !w_clr && rd_en;
  assign w_waddr  = w_clr ? r_clr_addr : wr_addr;
  assign w_wdata  = w_clr ? '0 : wr_data;

  // Next-state logic: init starts a sweep, the last address ends it.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (init) w_next = CLEAR;
      CLEAR:   if (w_last) w_next = IDLE;
      default: w_next = CLEAR;
    endcase
  end

  // State register; reset lands in CLEAR so a sweep follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  // Sweep pointer: walks up during CLEAR, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_addr <= '0;
    end else if (w_clr) begin
      r_clr_addr <= r_clr_addr + ADDR_W'(1);
    end else begin
      r_clr_addr <= '0;
    end
  end

  // Read valid pulses one cycle after each accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    assign w_bank_we[b] = w_clr || (w_wr_acc && wr_mask[b]);

    mem_bank #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_bank_we[b]),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata[b*DATA_W +: DATA_W]),
      .i_re    (w_rd_acc),
      .i_raddr (rd_addr),
      .o_rdata (w_bank_q[b*DATA_W +: DATA_W])
    );
  end

`ifdef MEM_BYPASS_EN
  logic [N_BANK-1:0] r_byp_hit;
  logic [W-1:0]      r_byp_data;
  logic              w_same;

  assign w_same = w_wr_acc && (wr_addr == rd_addr);

  // Capture which banks a colliding write hit, with its data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp_hit  <= '0;
      r_byp_data <= '0;
    end else if (w_rd_acc) begin
      r_byp_hit  <= {N_BANK{w_same}} & wr_mask;
      r_byp_data <= wr_data;
    end
  end

  // Per bank, pick forwarded write data over the stale array word.
  always_comb begin
    w_rd_word = w_bank_q;
    for (int b = 0; b < N_BANK; b++) begin
      if (r_byp_hit[b]) begin
        w_rd_word[b*DATA_W +: DATA_W] = r_byp_data[b*DATA_W +: DATA_W];
      end
    end
  end
`else
  assign w_rd_word = w_bank_q;
`endif

  assign busy     = w_clr;
  assign rd_valid = r_rd_valid;
  assign rd_data  = o_en ? w_rd_word : '0;

endmodule
